spi_tx_arbiter: RTL
===================

Name: spi_tx_arbiter

Overview:
Sequencer/arbiter in front of spi_transmitter; shares its single send path between three requesters: the sample-readback stream, the metadata dump, and ID/dataIn query responses. Drives one transfer at a time, waits for the transmitter's busy to fall, and supervises each transfer with a timeout. Sits between the core controller/sampler/metadata ROM and spi_transmitter.

Parameters:
META_AW, 5, metadata ROM address width; dump length capped at 2**META_AW bytes.
TIMEOUT_W, 16, width of the per-transfer busy-timeout counter.
TIMEOUT, 16'hFFFF, cycles of busy after acceptance before abort.

Ports:
clock  in  1  system clock, all logic on rising edge
extReset_n  in  1  asynchronous active-low reset
data_req  in  1  sampler has a word to send (level; held until data_ack)
data_word  in  32  sample word
data_valid  in  4  per-byte valid mask
data_ack  out  1  one-cycle pulse: word handed to transmitter
meta_start  in  1  pulse: begin metadata dump
meta_addr  out  META_AW  metadata ROM address
meta_rdata  in  8  ROM data, valid one cycle after meta_addr changes
meta_active  out  1  dump in progress
query_id  in  1  pulse: send "SLA1" signature
query_dataIn  in  1  pulse: send live dataIn word
tx_send  out  1  to transmitter send
tx_sendData  out  32  to transmitter send_data
tx_sendValid  out  4  to transmitter send_valid
tx_writeMeta  out  1  to transmitter writeMeta
tx_metaData  out  8  to transmitter meta_data
tx_queryId  out  1  to transmitter query_id
tx_queryDataIn  out  1  to transmitter query_dataIn
tx_busy  in  1  transmitter busy
arb_busy  out  1  any transfer or pending request outstanding
timeout_err  out  1  sticky; set on timeout, cleared by next meta_start or query pulse

Behaviour:
- Reset (async, extReset_n=0): state IDLE; all outputs 0; pending flags, meta_addr, timeout counter cleared.
- All tx_* strobes are registered one-cycle pulses; only one of tx_send/tx_writeMeta/tx_queryId/tx_queryDataIn high in any cycle.
- query_id/query_dataIn/meta_start pulses latched into pending flags (one each); a repeat pulse while pending is absorbed. query_id and query_dataIn in the same cycle: both latched, ID served first.
- Arbitration in IDLE, fixed priority: pending ID query > pending dataIn query > pending meta > data_req. Meta dump is atomic: once started, no query or data is interleaved until it ends.
- States: IDLE, META_RD, META_WR, ISSUE, WAIT_ACC, WAIT_DONE.
- IDLE, tx_busy=0, grant: query -> ISSUE with tx_queryId/tx_queryDataIn; data -> ISSUE with tx_send, tx_sendData=data_word, tx_sendValid=data_valid, data_ack same cycle; meta -> meta_addr=0, meta_active=1, META_RD. tx_busy=1 in IDLE: no grant.
- META_RD: one cycle for ROM latency -> META_WR.
- META_WR: tx_writeMeta=1, tx_metaData=meta_rdata; record last = (meta_rdata==0) or (meta_addr all-ones); -> WAIT_ACC.
- ISSUE: strobe cycle -> WAIT_ACC.
- WAIT_ACC: exactly one cycle (transmitter registers busy) -> WAIT_DONE; timeout counter cleared.
- WAIT_DONE: tx_busy=0 -> if meta and not last: meta_addr+1, META_RD; else meta_active=0, IDLE. tx_busy=1: counter increments; counter==TIMEOUT -> timeout_err=1, meta_active=0, drop meta pending, IDLE.
- Terminator byte 0x00 is transmitted, then dump ends. meta_addr wraps never; dump ends at all-ones address.
- meta_start during an active dump: ignored (not latched).
- arb_busy = (state!=IDLE) | any pending flag | data_req.
- Reset mid-transfer: immediate return to IDLE, nothing re-issued.

Decomposition:
- Package spi_tx_arb_pkg: state encoding constants (IDLE..WAIT_DONE), grant-source codes (GNT_ID, GNT_DIN, GNT_META, GNT_DATA), TIMEOUT default.
- One sub-module natural: spi_tx_arb_timeout (loadable counter with clear/enable, terminal-count flag); rest in one FSM.

Test Plan:
- data_req=1, data_word=32'hDEADBEEF, data_valid=4'hF, tx_busy model high 40 cycles -> one tx_send with that word, data_ack 1 cycle same cycle, next grant only after tx_busy falls.
- meta_start, ROM {8'h01,"A","B",8'h00} -> four tx_writeMeta pulses with 01,41,42,00 in order, meta_addr 0..3, meta_active falls after last busy drop.
- query_id and data_req both pending in IDLE -> tx_queryId first, tx_send only after busy drop; query_id+query_dataIn same cycle -> ID then dataIn.
- query_id pulse during meta dump of 3 bytes -> no tx_queryId until after terminator transfer completes, then exactly one.
- TIMEOUT=16'd20 override, tx_busy stuck high -> timeout_err=1 after 20 WAIT_DONE cycles, state IDLE, next meta_start clears timeout_err.
- extReset_n low mid-WAIT_DONE of a meta dump -> all outputs 0 asynchronously, meta_addr=0, no strobe after release without new request.

Source files
------------

// File: rtl/spi_tx_arb_pkg.sv
// Shared types and constants for the SPI transmit arbiter: FSM state
// encoding, grant-source codes and the default busy-timeout value.
package spi_tx_arb_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        META_RD   = 3'd1,
        META_WR   = 3'd2,
        ISSUE     = 3'd3,
        WAIT_ACC  = 3'd4,
        WAIT_DONE = 3'd5
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_ID   = 2'd0,
        GNT_DIN  = 2'd1,
        GNT_META = 2'd2,
        GNT_DATA = 2'd3
    } gnt_src_t;

    localparam int          TIMEOUT_W_DEFAULT = 16;
    localparam logic [15:0] TIMEOUT_DEFAULT   = 16'hFFFF;

    // A dump ends on the 0x00 terminator byte or on the last ROM address,
    // whichever comes first; the terminator itself is still transmitted.
    function automatic logic meta_is_last(input logic [7:0] rdata,
                                          input logic       addr_at_max);
        return (rdata == 8'h00) || addr_at_max;
    endfunction

endpackage

// File: rtl/spi_tx_arb_timeout.sv
// Per-transfer busy watchdog: counts cycles while enabled, restarts on
// clear, and flags when the count has reached the terminal value.
module spi_tx_arb_timeout #(
    parameter int                   TIMEOUT_W = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT   = '1
) (
    input  logic clock,
    input  logic extReset_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [TIMEOUT_W-1:0] count;

    // Cycle counter; clear has priority over enable.
    always_ff @(posedge clock or negedge extReset_n) begin
        if (!extReset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TIMEOUT);

endmodule

// File: rtl/spi_tx_arbiter.sv
// Shares the single spi_transmitter send path between the sample stream,
// the metadata dump and the ID / dataIn query responses. One transfer is
// in flight at a time; each is supervised by a busy timeout.
module spi_tx_arbiter
    import spi_tx_arb_pkg::*;
#(
    parameter int                   META_AW   = 5,
    parameter int                   TIMEOUT_W = TIMEOUT_W_DEFAULT,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT   = TIMEOUT_W'(TIMEOUT_DEFAULT)
) (
    input  logic               clock,
    input  logic               extReset_n,
    input  logic               data_req,
    input  logic [31:0]        data_word,
    input  logic [3:0]         data_valid,
    output logic               data_ack,
    input  logic               meta_start,
    output logic [META_AW-1:0] meta_addr,
    input  logic [7:0]         meta_rdata,
    output logic               meta_active,
    input  logic               query_id,
    input  logic               query_dataIn,
    output logic               tx_send,
    output logic [31:0]        tx_sendData,
    output logic [3:0]         tx_sendValid,
    output logic               tx_writeMeta,
    output logic [7:0]         tx_metaData,
    output logic               tx_queryId,
    output logic               tx_queryDataIn,
    input  logic               tx_busy,
    output logic               arb_busy,
    output logic               timeout_err
);

    arb_state_t state;
    logic       pend_id;
    logic       pend_din;
    logic       pend_meta;
    logic       meta_last;

    logic       any_pend;
    logic       gnt_vld;
    gnt_src_t   gnt_src;
    logic       to_clr;
    logic       to_en;
    logic       to_tc;
    logic       to_hit;

    spi_tx_arb_timeout #(
        .TIMEOUT_W (TIMEOUT_W),
        .TIMEOUT   (TIMEOUT)
    ) u_timeout (
        .clock      (clock),
        .extReset_n (extReset_n),
        .clr        (to_clr),
        .en         (to_en),
        .tc         (to_tc)
    );

    // Fixed-priority grant decision and watchdog control.
    always_comb begin
        any_pend = pend_id | pend_din | pend_meta;
        gnt_vld  = (state == IDLE) && !tx_busy && (any_pend || data_req);
        gnt_src  = GNT_DATA;
        if (pend_id) begin
            gnt_src = GNT_ID;
        end else if (pend_din) begin
            gnt_src = GNT_DIN;
        end else if (pend_meta) begin
            gnt_src = GNT_META;
        end
        to_clr = (state == WAIT_ACC);
        to_en  = (state == WAIT_DONE) && tx_busy && !to_tc;
        to_hit = (state == WAIT_DONE) && tx_busy && to_tc;
    end

    assign arb_busy = (state != IDLE) | any_pend | data_req;

    // Request latches: one flag per pulse source; repeats while pending are
    // absorbed, and meta_start is ignored while a dump is running.
    always_ff @(posedge clock or negedge extReset_n) begin
        if (!extReset_n) begin
            pend_id   <= 1'b0;
            pend_din  <= 1'b0;
            pend_meta <= 1'b0;
        end else begin
            if (gnt_vld && (gnt_src == GNT_ID)) begin
                pend_id <= 1'b0;
            end else if (query_id) begin
                pend_id <= 1'b1;
            end

            if (gnt_vld && (gnt_src == GNT_DIN)) begin
                pend_din <= 1'b0;
            end else if (query_dataIn) begin
                pend_din <= 1'b1;
            end

            if (to_hit || (gnt_vld && (gnt_src == GNT_META))) begin
                pend_meta <= 1'b0;
            end else if (meta_start && !meta_active) begin
                pend_meta <= 1'b1;
            end
        end
    end

    // Transfer sequencer with registered strobes and status outputs.
    always_ff @(posedge clock or negedge extReset_n) begin
        if (!extReset_n) begin
            state          <= IDLE;
            data_ack       <= 1'b0;
            meta_addr      <= '0;
            meta_active    <= 1'b0;
            meta_last      <= 1'b0;
            tx_send        <= 1'b0;
            tx_sendData    <= '0;
            tx_sendValid   <= '0;
            tx_writeMeta   <= 1'b0;
            tx_metaData    <= '0;
            tx_queryId     <= 1'b0;
            tx_queryDataIn <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            tx_send        <= 1'b0;
            tx_writeMeta   <= 1'b0;
            tx_queryId     <= 1'b0;
            tx_queryDataIn <= 1'b0;
            data_ack       <= 1'b0;

            if (to_hit) begin
                timeout_err <= 1'b1;
            end else if (meta_start || query_id || query_dataIn) begin
                timeout_err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        case (gnt_src)
                            GNT_ID: begin
                                tx_queryId <= 1'b1;
                                state      <= ISSUE;
                            end
                            GNT_DIN: begin
                                tx_queryDataIn <= 1'b1;
                                state          <= ISSUE;
                            end
                            GNT_META: begin
                                meta_addr   <= '0;
                                meta_active <= 1'b1;
                                state       <= META_RD;
                            end
                            GNT_DATA: begin
                                tx_send      <= 1'b1;
                                tx_sendData  <= data_word;
                                tx_sendValid <= data_valid;
                                data_ack     <= 1'b1;
                                state        <= ISSUE;
                            end
                        endcase
                    end
                end
                // ROM output lags the address by one cycle.
                META_RD: begin
                    state <= META_WR;
                end
                META_WR: begin
                    tx_writeMeta <= 1'b1;
                    tx_metaData  <= meta_rdata;
                    meta_last    <= meta_is_last(meta_rdata, &meta_addr);
                    state        <= WAIT_ACC;
                end
                ISSUE: begin
                    state <= WAIT_ACC;
                end
                // Transmitter needs a cycle to raise busy after the strobe.
                WAIT_ACC: begin
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (meta_active && !meta_last) begin
                            meta_addr <= meta_addr + 1'b1;
                            state     <= META_RD;
                        end else begin
                            meta_active <= 1'b0;
                            state       <= IDLE;
                        end
                    end else if (to_tc) begin
                        meta_active <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
